// File: rtl/fetch_ctrl_unit.sv
// IF-stage controller: owns the PC and IF/ID register, drives the imem request/ack
// handshake, and parks an acked instruction in a skid buffer on stall. Optional FETCH_TIMEOUT_EN.
module fetch_ctrl_unit #(
    parameter int PC_W        = 16,
    parameter int INSTR_W     = 16,
    parameter int RESET_PC    = 0,
    parameter int PC_INC      = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcstall,
    input  logic               IF_IDstall,
    input  logic               flushIF_ID,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    fetch_pc,
    output logic               fetch_err
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    state_t             state_q, state_n;
    logic [PC_W-1:0]    pc_q, pc_n;
    logic [INSTR_W-1:0] skid_q, skid_n;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_n;
    logic [PC_W-1:0]    stale_q, stale_n;
    logic [INSTR_W-1:0] instr_n;
    logic [PC_W-1:0]    ifpc_n;
    logic               valid_n;
    logic               stall_f;

    assign stall_f   = pcstall | IF_IDstall;
    assign fetch_pc  = pc_q;
    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = (state_q == DISCARD) ? stale_q : pc_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_n   = state_q;
        pc_n      = pc_q;
        skid_n    = skid_q;
        skid_pc_n = skid_pc_q;
        stale_n   = stale_q;
        instr_n   = ifid_instr;
        ifpc_n    = ifid_pc;
        valid_n   = ifid_valid;

        if (redirect_valid) begin
            // Redirect wins over every stall; any in-flight or parked fetch is squashed.
            pc_n    = redirect_pc;
            instr_n = '0;
            valid_n = 1'b0;
            case (state_q)
                FETCH: begin
                    if (!imem_ack) begin
                        stale_n = pc_q;
                        state_n = DISCARD;
                    end
                end
                DISCARD: state_n = imem_ack ? FETCH : DISCARD;
                default: state_n = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_n = pc_q + PC_STEP;
                        if (!stall_f) begin
                            instr_n = imem_rdata;
                            ifpc_n  = pc_q;
                            valid_n = 1'b1;
                        end else begin
                            skid_n    = imem_rdata;
                            skid_pc_n = pc_q;
                            state_n   = HOLD;
                        end
                    end else if (!stall_f) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_f) begin
                        instr_n = skid_q;
                        ifpc_n  = skid_pc_q;
                        valid_n = 1'b1;
                        state_n = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack) state_n = FETCH;
                    if (!IF_IDstall) begin
                        instr_n = '0;
                        valid_n = 1'b0;
                    end
                end
                default: state_n = FETCH;
            endcase
            // A flush beats IF_IDstall; the PC still advances past a dropped instruction.
            if (flushIF_ID) begin
                instr_n = '0;
                valid_n = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= PC_RST;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            stale_q    <= '0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            skid_q     <= skid_n;
            skid_pc_q  <= skid_pc_n;
            stale_q    <= stale_n;
            ifid_instr <= instr_n;
            ifid_pc    <= ifpc_n;
            ifid_valid <= valid_n;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    logic [7:0] to_cnt_q;
    logic [7:0] to_cnt_inc;
    logic       err_q;

    assign to_cnt_inc = to_cnt_q + 8'd1;

    // Counts cycles spent waiting on an unacknowledged request; the error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (imem_ack) begin
            to_cnt_q <= '0;
        end else if (imem_req) begin
            if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_inc;
            if (to_cnt_q != 8'hFF && to_cnt_inc == TO_LIM) err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Self-checking bench for fetch_ctrl_unit: a latency-programmable memory model plus a
// scoreboard of instructions the ID stage is expected to consume, in order.
module tb_fetch_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcstall;
    logic        IF_IDstall;
    logic        flushIF_ID;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'hDEAD;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic [15:0] fetch_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int lat     = 0;
    int mem_cnt = 0;
    logic [15:0] last_addr = '0;
    logic [15:0] exp_q[$];

`ifdef FETCH_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    always #5 clk = ~clk;

    fetch_ctrl_unit #(
        .PC_W(16), .INSTR_W(16), .RESET_PC(0), .PC_INC(1), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .rst(rst), .pcstall(pcstall), .IF_IDstall(IF_IDstall),
        .flushIF_ID(flushIF_ID), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_valid(ifid_valid), .fetch_pc(fetch_pc), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 16'(i));
    endtask

    // Negedge: ID consumes IF/ID when not stalled, then the memory decides this cycle's ack.
    always @(negedge clk) begin
        logic [15:0] e;
        if (ifid_valid === 1'b1 && IF_IDstall === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", {16'h0, ifid_pc}, {16'h0, e});
                check("sb_instr", {16'h0, ifid_instr}, {16'h0, e + 16'h1000});
            end
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        if (imem_req === 1'b1) begin
            if (mem_cnt > 0) check("addr_stable", {16'h0, imem_addr}, {16'h0, last_addr});
            last_addr = imem_addr;
            if (mem_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr + 16'h1000;
                mem_cnt    = 0;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   {31'h0, imem_req},   32'h0);
        check({tag, "_valid"}, {31'h0, ifid_valid}, 32'h0);
        check({tag, "_instr"}, {16'h0, ifid_instr}, 32'h0);
        check({tag, "_ifpc"},  {16'h0, ifid_pc},    32'h0);
        check({tag, "_pc"},    {16'h0, fetch_pc},   32'h0);
        check({tag, "_err"},   {31'h0, fetch_err},  32'h0);
    endtask

    initial begin
        rst = 1'b1; pcstall = 1'b0; IF_IDstall = 1'b0; flushIF_ID = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(2);
        check_reset_state("rst0");

        // Zero-wait memory: one instruction per cycle.
        push_range(16'h0000, 10);
        rst = 1'b0;
        step(1);
        check("first_valid", {31'h0, ifid_valid}, 32'h1);
        check("first_pc",    {16'h0, ifid_pc},    32'h0);
        check("first_instr", {16'h0, ifid_instr}, 32'h1000);
        step(4);
        check("pc4", {16'h0, ifid_pc}, 32'h4);

        // IF/ID stall while pc 5 is acked: parked in skid, released in order.
        IF_IDstall = 1'b1;
        step(1);
        check("hold_req",  {31'h0, imem_req}, 32'h0);
        check("hold_ifpc", {16'h0, ifid_pc},  32'h4);
        check("hold_pc",   {16'h0, fetch_pc}, 32'h6);
        step(2);
        check("hold3_ifpc", {16'h0, ifid_pc},  32'h4);
        check("hold3_req",  {31'h0, imem_req}, 32'h0);
        IF_IDstall = 1'b0;
        step(1);
        check("rel_pc",    {16'h0, ifid_pc},    32'h5);
        check("rel_instr", {16'h0, ifid_instr}, 32'h1005);
        step(4);
        check("pc9", {16'h0, ifid_pc}, 32'h9);

        // Latency 3: two bubbles between instructions, address held.
        lat = 2;
        push_range(16'h000A, 2);
        exp_q.push_back(16'h0040);
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("bub_valid", {31'h0, ifid_valid}, 32'h0);
            check("bub_instr", {16'h0, ifid_instr}, 32'h0);
            check("bub_addr",  {16'h0, imem_addr},  32'hA);
        end
        step(1);
        check("lat_pc10", {16'h0, ifid_pc}, 32'hA);
        step(3);
        check("lat_pc11", {16'h0, ifid_pc}, 32'hB);

        // Redirect while pc 12 is outstanding: stale data must be dropped.
        step(1);
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step(1);
        redirect_valid = 1'b0;
        check("disc_addr",  {16'h0, imem_addr},  32'hC);
        check("disc_req",   {31'h0, imem_req},   32'h1);
        check("disc_pc",    {16'h0, fetch_pc},   32'h40);
        check("disc_valid", {31'h0, ifid_valid}, 32'h0);
        step(1);
        check("post_disc_addr",  {16'h0, imem_addr},  32'h40);
        check("post_disc_valid", {31'h0, ifid_valid}, 32'h0);
        step(3);
        check("tgt_pc", {16'h0, ifid_pc}, 32'h40);

        // Redirect with same-cycle ack, then PC wrap at 0xFFFF.
        lat = 0;
        exp_q.push_back(16'h0041);
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        step(1);
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step(1);
        redirect_valid = 1'b0;
        check("rda_valid", {31'h0, ifid_valid}, 32'h0);
        check("rda_pc",    {16'h0, fetch_pc},   32'hFFFE);
        step(2);
        check("wrap_ifpc", {16'h0, ifid_pc},  32'hFFFF);
        check("wrap_pc",   {16'h0, fetch_pc}, 32'h0);
        step(1);
        check("wrap0_ifpc", {16'h0, ifid_pc}, 32'h0);

        // Redirect + IF/ID stall + flush together: bubble, pc = target.
        redirect_valid = 1'b1; redirect_pc = 16'h0100; IF_IDstall = 1'b1; flushIF_ID = 1'b1;
        step(1);
        redirect_valid = 1'b0; IF_IDstall = 1'b0; flushIF_ID = 1'b0;
        check("rsf_valid", {31'h0, ifid_valid}, 32'h0);
        check("rsf_instr", {16'h0, ifid_instr}, 32'h0);
        check("rsf_pc",    {16'h0, fetch_pc},   32'h100);
        check("rsf_addr",  {16'h0, imem_addr},  32'h100);
        exp_q.push_back(16'h0100);
        step(1);
        check("rsf_ifpc", {16'h0, ifid_pc}, 32'h100);
        rst = 1'b1;
        step(1);
        check_reset_state("rst1");

        // Flush alone drops the acked instruction but the PC advances past it.
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0002);
        rst = 1'b0;
        step(1);
        flushIF_ID = 1'b1;
        step(1);
        flushIF_ID = 1'b0;
        check("fl_valid", {31'h0, ifid_valid}, 32'h0);
        check("fl_pc",    {16'h0, fetch_pc},   32'h2);
        step(1);
        check("fl_ifpc", {16'h0, ifid_pc}, 32'h2);
        rst = 1'b1;
        step(1);

        // Withheld ack: fetch_err rises on the 10th waiting cycle when the timeout is built in.
        exp_q.push_back(16'h0000);
        lat = 100;
        rst = 1'b0;
        step(9);
        check("to_err9", {31'h0, fetch_err}, 32'h0);
        step(1);
        check("to_err10", {31'h0, fetch_err}, {31'h0, EXP_TO});
        step(2);
        check("to_err12",  {31'h0, fetch_err},  {31'h0, EXP_TO});
        check("to_addr",   {16'h0, imem_addr},  32'h0);
        check("to_valid",  {31'h0, ifid_valid}, 32'h0);
        lat = 0;
        step(1);
        check("to_ack_ifpc", {16'h0, ifid_pc},   32'h0);
        check("to_sticky",   {31'h0, fetch_err}, {31'h0, EXP_TO});
        rst = 1'b1;
        step(1);
        check("to_clear", {31'h0, fetch_err}, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
